// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver producing the 11-bit toggle-format key event word.
// Optional typematic repeat suppression: define PS2_TYPEMATIC_FILTER_EN.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          fclk, fclk_d, fall;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg, byte_q;
    logic          par, byte_vld;
    logic          shift_en, par_cap, byte_ok, byte_bad;
    logic          ext, rel, prefix, special, suppress, emit;

    // Two-flop synchronizers for both PS/2 lines
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    // Debounce the clock: follow it only after FILTER_LEN stable differing samples
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            fcnt   <= '0;
            fclk   <= 1'b1;
            fclk_d <= 1'b1;
        end else begin
            fclk_d <= fclk;
            if (clk_sync != fclk) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    fclk <= clk_sync;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall    = fclk_d & ~fclk;
    assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));

    // Inactivity counter for aborting stalled frames
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (fall || state == IDLE) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Receiver next state and per-edge strobes
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        par_cap  = 1'b0;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (timeout) begin
            state_n = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!dat_sync) state_n = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_cap = 1'b1;
                    state_n = STOP;
                end
                STOP: begin
                    if (dat_sync && (^{shreg, par})) byte_ok = 1'b1;
                    else byte_bad = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Receiver state, shift register and error strobe
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            byte_vld  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            byte_vld  <= byte_ok;
            frame_err <= byte_bad | timeout;
            if (state == IDLE) bitcnt <= '0;
            else if (shift_en) bitcnt <= bitcnt + 3'd1;
            if (shift_en) shreg <= {dat_sync, shreg[7:1]};
            if (par_cap) par <= dat_sync;
            if (byte_ok) byte_q <= shreg;
        end
    end

    assign prefix  = (byte_q == 8'hE0) || (byte_q == 8'hF0);
    assign special = (byte_q == 8'h00) || (byte_q == 8'hAA) ||
                     (byte_q == 8'hEE) || (byte_q == 8'hFA) ||
                     (byte_q == 8'hFE) || (byte_q == 8'hFF);

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       lm_vld;

    assign suppress = !rel && lm_vld && (last_make == {ext, byte_q});

    // Remember the last emitted make code to drop keyboard auto-repeats
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_make <= '0;
            lm_vld    <= 1'b0;
        end else if (emit) begin
            if (!rel) begin
                last_make <= {ext, byte_q};
                lm_vld    <= 1'b1;
            end else if (last_make == {ext, byte_q}) begin
                lm_vld <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign emit = byte_vld && !prefix && !special && !suppress;

    // Prefix tracking and key event emission
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext     <= 1'b0;
            rel     <= 1'b0;
            ps2_key <= '0;
        end else if (frame_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end else if (byte_vld) begin
            if (byte_q == 8'hE0) begin
                ext <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                rel <= 1'b1;
            end else begin
                ext <= 1'b0;
                rel <= 1'b0;
                if (emit) ps2_key <= {~ps2_key[10], ~rel, ext, byte_q};
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed testbench for ps2_key_encoder: table of frames plus corner sequences.
module tb_ps2_key_encoder;

    localparam int HALF = 50;
    localparam int TO   = 2000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int errs  = 0;
    int dbl   = 0;
    int togs  = 0;
    logic err_prev = 1'b0;
    logic tog_prev = 1'b0;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Count error pulses, back-to-back errors and toggle flips
    always @(negedge clk_sys) begin
        if (frame_err) errs++;
        if (frame_err && err_prev) dbl++;
        err_prev = frame_err;
        if (ps2_key[10] != tog_prev) togs++;
        tog_prev = ps2_key[10];
    end

    typedef struct {
        logic [7:0]  b;
        logic        bad;
        logic [10:0] key;
        int          err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clk_sys);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk_sys);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b,
                                            input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic frame(input logic [7:0] b, input logic bad);
        send_bits(mkframe(b, bad), 11);
        ps2_data = 1'b1;
        repeat (40) @(posedge clk_sys);
    endtask

    initial begin
        int e0, t0;
        vecs[0]  = '{8'h29, 1'b0, 11'h629, 0};
        vecs[1]  = '{8'hE0, 1'b0, 11'h629, 0};
        vecs[2]  = '{8'hF0, 1'b0, 11'h629, 0};
        vecs[3]  = '{8'h75, 1'b0, 11'h175, 0};
        vecs[4]  = '{8'h1C, 1'b1, 11'h175, 1};
        vecs[5]  = '{8'h1C, 1'b0, 11'h61C, 0};
        vecs[6]  = '{8'hFA, 1'b0, 11'h61C, 0};
        vecs[7]  = '{8'hF0, 1'b0, 11'h61C, 0};
        vecs[8]  = '{8'hFA, 1'b0, 11'h61C, 0};
        vecs[9]  = '{8'h16, 1'b0, 11'h216, 0};
        vecs[10] = '{8'hE0, 1'b0, 11'h216, 0};
        vecs[11] = '{8'h1C, 1'b1, 11'h216, 1};
        vecs[12] = '{8'h34, 1'b0, 11'h634, 0};

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("reset_key", 32'(ps2_key), 32'h0);
        chk("reset_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk_sys);

        for (int i = 0; i < 13; i++) begin
            e0 = errs;
            frame(vecs[i].b, vecs[i].bad);
            @(negedge clk_sys);
            chk($sformatf("vec%0d_key", i), 32'(ps2_key), 32'(vecs[i].key));
            chk($sformatf("vec%0d_err", i), 32'(errs - e0), 32'(vecs[i].err));
        end

        // Typematic repeats followed by break
        t0 = togs;
        frame(8'h6B, 1'b0);
        frame(8'h6B, 1'b0);
        frame(8'h6B, 1'b0);
        frame(8'hF0, 1'b0);
        frame(8'h6B, 1'b0);
        @(negedge clk_sys);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typematic_togs", 32'(togs - t0), 32'd2);
`else
        chk("typematic_togs", 32'(togs - t0), 32'd4);
`endif
        chk("typematic_key", 32'(ps2_key[9:0]), 32'h06B);

        // Partial frame abandoned until timeout
        e0 = errs;
        send_bits(mkframe(8'h55, 1'b0), 5);
        ps2_data = 1'b1;
        repeat (TO + 300) @(posedge clk_sys);
        chk("timeout_err", 32'(errs - e0), 32'd1);
        frame(8'h16, 1'b0);
        @(negedge clk_sys);
        chk("after_timeout_key", 32'(ps2_key), 32'h216);
        chk("after_timeout_err", 32'(errs - e0), 32'd1);

        // Short clock glitch with data low must not start a frame
        e0 = errs;
        frame(8'hF0, 1'b0);
        ps2_data = 1'b0;
        @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (30) @(posedge clk_sys);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk_sys);
        frame(8'hFA, 1'b0);
        @(negedge clk_sys);
        chk("glitch_ack_key", 32'(ps2_key), 32'h216);
        chk("glitch_ack_err", 32'(errs - e0), 32'd0);
        frame(8'h29, 1'b0);
        @(negedge clk_sys);
        chk("flags_cleared_key", 32'(ps2_key), 32'h629);

        // Reset in the middle of a frame
        send_bits(mkframe(8'h33, 1'b0), 4);
        ps2_data = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("midreset_key", 32'(ps2_key), 32'h0);
        chk("midreset_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (10) @(posedge clk_sys);
        e0 = errs;
        frame(8'h29, 1'b0);
        @(negedge clk_sys);
        chk("post_reset_key", 32'(ps2_key), 32'h629);
        chk("post_reset_err", 32'(errs - e0), 32'd0);

        chk("err_single_cycle", 32'(dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
